// File: rtl/fp_mul_core_if.sv
// Handshake and result bundle for fp_mul_core.
// The requester drives start/a/b; the core returns busy, done and the unpacked
// product (sign, normalized mantissa, unbiased exponent).
interface fp_mul_core_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        sign;
    logic [23:0] nMantissa;
    logic [8:0]  uExp;
    logic        done;

    modport master (output start, a, b, input busy, sign, nMantissa, uExp, done);
    modport slave  (input start, a, b, output busy, sign, nMantissa, uExp, done);
endinterface

// File: rtl/fp_mul_core.sv
// Sequential IEEE-754 single-precision mantissa/exponent multiplier.
// Operands are captured on an accepted start, multiplied with a 24-step
// shift-add loop, then normalized so the hidden bit lands at nMantissa[23].
// The result is handed to a downstream normalizer via a one-cycle done pulse.
// Optional macro FP_MUL_ROUND_EN adds a round-to-nearest-even step (one extra
// NORM cycle); without it the mantissa is truncated.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands captured and unpacked on start
// MUL   | 24 shift-add steps, one multiplier bit per cycle
// NORM  | align product so bit 46 is the leading one, load outputs
// DONE  | done pulse for one cycle, then back to IDLE
module fp_mul_core (
    input  logic          clk,
    input  logic          rst,
    fp_mul_core_if.slave  mul_if
);
    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_sign;
    logic [23:0]        r_mant;
    logic [8:0]         r_uexp;
    logic               r_sign_c;
    logic               r_zero;
    logic [47:0]        r_mcand;
    logic [23:0]        r_mplier;
    logic [47:0]        r_prod;
    logic signed [9:0]  r_exp;
    logic [4:0]         r_cnt;
    logic [5:0]         r_shift_cnt;
    logic               r_first;

    logic signed [9:0]  w_exp_a;
    logic signed [9:0]  w_exp_b;
    logic [47:0]        w_prod_adj;
    logic signed [9:0]  w_exp_adj;
    logic               w_exit;

    // Saturate the unbiased exponent into the 9-bit two's-complement output.
    function automatic logic [8:0] clamp_exp(input logic signed [9:0] e);
        if (e > 10'sd255)
            return 9'h0FF;
        else if (e < -10'sd256)
            return 9'h100;
        else
            return e[8:0];
    endfunction

    // Unbiased exponents; denormals use the fixed -126 with a zero hidden bit.
    assign w_exp_a = (mul_if.a[30:23] == 8'd0) ? -10'sd126
                   : $signed({2'b00, mul_if.a[30:23]}) - 10'sd127;
    assign w_exp_b = (mul_if.b[30:23] == 8'd0) ? -10'sd126
                   : $signed({2'b00, mul_if.b[30:23]}) - 10'sd127;

    // Only the first NORM cycle can see a product >= 2.0; fold that right
    // shift into the same cycle so normal operands leave NORM immediately.
    assign w_prod_adj = (r_first && r_prod[47]) ? (r_prod >> 1) : r_prod;
    assign w_exp_adj  = (r_first && r_prod[47]) ? (r_exp + 10'sd1) : r_exp;
    assign w_exit     = r_zero || w_prod_adj[46] || (r_shift_cnt == 6'd0);

`ifdef FP_MUL_ROUND_EN
    logic               w_inc;
    logic [24:0]        w_mant_rnd;
    logic [23:0]        w_mant_fin;
    logic signed [9:0]  w_exp_rnd;
    logic               r_rnd;

    // Nearest-even on the already aligned product held in r_prod.
    assign w_inc      = r_prod[22] & ((|r_prod[21:0]) | r_prod[23]);
    assign w_mant_rnd = {1'b0, r_prod[46:23]} + {24'd0, w_inc};
    assign w_mant_fin = w_mant_rnd[24] ? 24'h800000 : w_mant_rnd[23:0];
    assign w_exp_rnd  = w_mant_rnd[24] ? (r_exp + 10'sd1) : r_exp;
`endif

    // Sequencer plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sign      <= 1'b0;
            r_mant      <= 24'd0;
            r_uexp      <= 9'd0;
            r_sign_c    <= 1'b0;
            r_zero      <= 1'b0;
            r_mcand     <= 48'd0;
            r_mplier    <= 24'd0;
            r_prod      <= 48'd0;
            r_exp       <= 10'sd0;
            r_cnt       <= 5'd0;
            r_shift_cnt <= 6'd0;
            r_first     <= 1'b0;
`ifdef FP_MUL_ROUND_EN
            r_rnd       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (mul_if.start) begin
                        r_sign_c <= mul_if.a[31] ^ mul_if.b[31];
                        r_zero   <= (mul_if.a[30:0] == 31'd0) || (mul_if.b[30:0] == 31'd0);
                        r_mcand  <= {24'd0, (mul_if.a[30:23] != 8'd0), mul_if.a[22:0]};
                        r_mplier <= {(mul_if.b[30:23] != 8'd0), mul_if.b[22:0]};
                        r_prod   <= 48'd0;
                        r_exp    <= w_exp_a + w_exp_b;
                        r_cnt    <= 5'd23;
                        r_busy   <= 1'b1;
                        r_state  <= MUL;
                    end
                end
                MUL: begin
                    if (r_mplier[0])
                        r_prod <= r_prod + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == 5'd0) begin
                        r_first     <= 1'b1;
                        r_shift_cnt <= 6'd47;
`ifdef FP_MUL_ROUND_EN
                        r_rnd       <= 1'b0;
`endif
                        r_state     <= NORM;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                NORM: begin
                    r_first <= 1'b0;
`ifdef FP_MUL_ROUND_EN
                    if (r_rnd) begin
                        r_sign  <= r_sign_c;
                        r_mant  <= r_zero ? 24'd0 : w_mant_fin;
                        r_uexp  <= r_zero ? 9'h100 : clamp_exp(w_exp_rnd);
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_exit) begin
                        r_prod <= w_prod_adj;
                        r_exp  <= w_exp_adj;
                        r_rnd  <= 1'b1;
                    end else begin
                        r_prod      <= w_prod_adj << 1;
                        r_exp       <= w_exp_adj - 10'sd1;
                        r_shift_cnt <= r_shift_cnt - 6'd1;
                    end
`else
                    if (w_exit) begin
                        r_sign  <= r_sign_c;
                        r_mant  <= r_zero ? 24'd0 : w_prod_adj[46:23];
                        r_uexp  <= r_zero ? 9'h100 : clamp_exp(w_exp_adj);
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_prod      <= w_prod_adj << 1;
                        r_exp       <= w_exp_adj - 10'sd1;
                        r_shift_cnt <= r_shift_cnt - 6'd1;
                    end
`endif
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mul_if.busy      = r_busy;
    assign mul_if.done      = r_done;
    assign mul_if.sign      = r_sign;
    assign mul_if.nMantissa = r_mant;
    assign mul_if.uExp      = r_uexp;
endmodule

// File: tb/tb_fp_mul_core.sv
// Bench for fp_mul_core: a reference model built on the native multiply
// operator predicts each result and its done cycle; expectations are queued at
// start and popped when done is observed. Cycle 1 is the cycle right after the
// start-accept edge, so a normal operand pair reports done in cycle 26.
module tb_fp_mul_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_mul_core_if mul_if();
    fp_mul_core dut (.clk(clk), .rst(rst), .mul_if(mul_if));

    typedef struct {
        logic        sign;
        logic [23:0] mant;
        logic [8:0]  uexp;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    localparam int LIMIT = 200;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        logic [47:0] p;
        logic [47:0] np;
        logic [24:0] m25;
        int          ea, eb, e, lead, nc;
        ea = (a[30:23] == 8'd0) ? -126 : int'(a[30:23]) - 127;
        eb = (b[30:23] == 8'd0) ? -126 : int'(b[30:23]) - 127;
        r.sign = a[31] ^ b[31];
        nc = 1;
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) begin
            r.mant = 24'd0;
            r.uexp = 9'h100;
        end else begin
            p = 48'({(a[30:23] != 8'd0), a[22:0]}) * 48'({(b[30:23] != 8'd0), b[22:0]});
            lead = -1;
            for (int i = 47; i >= 0; i--)
                if (p[i] && lead < 0) lead = i;
            np = (lead == 47) ? (p >> 1) : (p << (46 - lead));
            e  = ea + eb + lead - 46;
            if (lead < 46) nc = 1 + (46 - lead);
            m25 = {1'b0, np[46:23]};
`ifdef FP_MUL_ROUND_EN
            if (np[22] && ((|np[21:0]) || np[23])) m25 = m25 + 25'd1;
            if (m25[24]) begin
                m25 = 25'h0800000;
                e   = e + 1;
            end
`endif
            r.mant = m25[23:0];
            if (e > 255)       r.uexp = 9'h0FF;
            else if (e < -256) r.uexp = 9'h100;
            else               r.uexp = e[8:0];
        end
`ifdef FP_MUL_ROUND_EN
        nc = nc + 1;
`endif
        r.lat = 25 + nc;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start for one edge (the accept edge); optionally queue the expectation.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit push);
        mul_if.a     = a;
        mul_if.b     = b;
        mul_if.start = 1'b1;
        if (push) sb_q.push_back(model(a, b));
        tick();
        mul_if.start = 1'b0;
    endtask

    task automatic wait_done(input int cyc0, output logic got, output int cyc);
        cyc = cyc0;
        got = 1'b0;
        while (cyc < LIMIT) begin
            if (mul_if.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mul_if.start = 1'b1;
        mul_if.a = 32'h3F800000;
        mul_if.b = 32'h3F800000;
        repeat (3) tick();
        n_checks++;
        if ({mul_if.busy, mul_if.done, mul_if.sign, mul_if.nMantissa, mul_if.uExp} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b sign=%b mant=%h uexp=%h, expected all zero",
                     mul_if.busy, mul_if.done, mul_if.sign, mul_if.nMantissa, mul_if.uExp);
        end
        rst = 1'b0;
        mul_if.start = 1'b0;
        tick();
        n_checks++;
        if (mul_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: busy=%b expected 0", mul_if.busy);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] tv_a [8] = '{32'h3F800000, 32'hC0400000, 32'h7F7FFFFF, 32'h00000000,
                                  32'h00400000, 32'h7F800000, 32'h00000001, 32'h7F800000};
        logic [31:0] tv_b [8] = '{32'h3F800000, 32'h40800000, 32'h7F7FFFFF, 32'h3FC00000,
                                  32'h3F800000, 32'h3F800000, 32'h00000001, 32'h7F800000};
        logic [31:0] a, b;
        exp_t ex;
        logic got;
        int   cyc;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                a = tv_a[i];
                b = tv_b[i];
            end else begin
                a = $urandom;
                b = $urandom;
                if (i % 3 == 0) a[30:23] = 8'd0;
            end
            launch(a, b, 1'b1);
            wait_done(1, got, cyc);
            ex = sb_q.pop_front();
            n_checks++;
            if (got !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_timeout: no done within %0d cycles", i, LIMIT);
            end
            n_checks++;
            if (cyc !== ex.lat) begin
                n_fail++;
                $display("FAIL vec%0d_latency: done in cycle %0d expected %0d", i, cyc, ex.lat);
            end
            n_checks++;
            if ({mul_if.sign, mul_if.nMantissa, mul_if.uExp} !== {ex.sign, ex.mant, ex.uexp}) begin
                n_fail++;
                $display("FAIL vec%0d_result a=%h b=%h: got sign=%b mant=%h uexp=%h expected sign=%b mant=%h uexp=%h",
                         i, a, b, mul_if.sign, mul_if.nMantissa, mul_if.uExp, ex.sign, ex.mant, ex.uexp);
            end
            tick();
            n_checks++;
            if ({mul_if.done, mul_if.busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL vec%0d_pulse: done=%b busy=%b expected 0 0", i, mul_if.done, mul_if.busy);
            end
            tick();
            tick();
            n_checks++;
            if ({mul_if.sign, mul_if.nMantissa, mul_if.uExp} !== {ex.sign, ex.mant, ex.uexp}) begin
                n_fail++;
                $display("FAIL vec%0d_hold: got mant=%h uexp=%h expected mant=%h uexp=%h",
                         i, mul_if.nMantissa, mul_if.uExp, ex.mant, ex.uexp);
            end
        end
    endtask

    task automatic test_start_while_busy();
        exp_t ex;
        logic got;
        int   cyc, extra;
        launch(32'hC0400000, 32'h40800000, 1'b1);
        cyc = 1;
        while (cyc < 4) begin
            tick();
            cyc++;
        end
        mul_if.a = 32'h3F800000;
        mul_if.b = 32'h3FC00000;
        mul_if.start = 1'b1;
        tick();
        cyc++;
        mul_if.start = 1'b0;
        wait_done(cyc, got, cyc);
        ex = sb_q.pop_front();
        n_checks++;
        if (got !== 1'b1 || cyc !== ex.lat) begin
            n_fail++;
            $display("FAIL busy_start_latency: got=%b cycle %0d expected cycle %0d", got, cyc, ex.lat);
        end
        n_checks++;
        if ({mul_if.sign, mul_if.nMantissa, mul_if.uExp} !== {ex.sign, ex.mant, ex.uexp}) begin
            n_fail++;
            $display("FAIL busy_start_result: got sign=%b mant=%h uexp=%h expected sign=%b mant=%h uexp=%h",
                     mul_if.sign, mul_if.nMantissa, mul_if.uExp, ex.sign, ex.mant, ex.uexp);
        end
        extra = 0;
        repeat (60) begin
            tick();
            if (mul_if.done === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0 || sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL busy_start_queued: extra done pulses=%0d expected 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, extra;
        launch(32'h3FC00000, 32'h40000000, 1'b0);
        cyc = 1;
        while (cyc < 9) begin
            tick();
            cyc++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({mul_if.busy, mul_if.done, mul_if.sign, mul_if.nMantissa, mul_if.uExp} !== 36'd0) begin
            n_fail++;
            $display("FAIL abort_clear: got busy=%b done=%b sign=%b mant=%h uexp=%h expected all zero",
                     mul_if.busy, mul_if.done, mul_if.sign, mul_if.nMantissa, mul_if.uExp);
        end
        extra = 0;
        repeat (60) begin
            tick();
            if (mul_if.done === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        exp_t ex;
        logic got;
        int   cyc;
        launch(32'h40400000, 32'h40400000, 1'b1);
        wait_done(1, got, cyc);
        ex = sb_q.pop_front();
        n_checks++;
        if (got !== 1'b1 || {mul_if.sign, mul_if.nMantissa, mul_if.uExp} !== {ex.sign, ex.mant, ex.uexp}) begin
            n_fail++;
            $display("FAIL b2b_first: got=%b mant=%h uexp=%h expected mant=%h uexp=%h",
                     got, mul_if.nMantissa, mul_if.uExp, ex.mant, ex.uexp);
        end
        mul_if.a = 32'hBF000000;
        mul_if.b = 32'h40A00000;
        mul_if.start = 1'b1;
        sb_q.push_back(model(32'hBF000000, 32'h40A00000));
        tick();
        n_checks++;
        if (mul_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_start_ignored: busy=%b expected 0", mul_if.busy);
        end
        tick();
        mul_if.start = 1'b0;
        n_checks++;
        if (mul_if.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle_start_accepted: busy=%b expected 1", mul_if.busy);
        end
        wait_done(1, got, cyc);
        ex = sb_q.pop_front();
        n_checks++;
        if (got !== 1'b1 || cyc !== ex.lat) begin
            n_fail++;
            $display("FAIL b2b_second_latency: got=%b cycle %0d expected %0d", got, cyc, ex.lat);
        end
        n_checks++;
        if ({mul_if.sign, mul_if.nMantissa, mul_if.uExp} !== {ex.sign, ex.mant, ex.uexp}) begin
            n_fail++;
            $display("FAIL b2b_second_result: got sign=%b mant=%h uexp=%h expected sign=%b mant=%h uexp=%h",
                     mul_if.sign, mul_if.nMantissa, mul_if.uExp, ex.sign, ex.mant, ex.uexp);
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mul_if.start = 1'b0;
        mul_if.a = 32'd0;
        mul_if.b = 32'd0;
        test_reset();
        test_vectors();
        test_start_while_busy();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_mul_core.md
FP_MUL_CORE -- requirements
Module: fp_mul_core

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; there are no parameters.
REQ-002 Port `clk`: input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `start`: input, 1 bit, request strobe; sampled only in IDLE.
REQ-005 Port `a`: input, 32 bits, IEEE-754 single operand A; captured on accepted start.
REQ-006 Port `b`: input, 32 bits, IEEE-754 single operand B; captured on accepted start.
REQ-007 Port `busy`: output, 1 bit, high in every state except IDLE.
REQ-008 Port `sign`: output, 1 bit, product sign, a[31] XOR b[31].
REQ-009 Port `nMantissa`: output, 24 bits, normalized product mantissa with the hidden bit at [23].
REQ-010 Port `uExp`: output, 9 bits, two's-complement unbiased product exponent.
REQ-011 Port `done`: output, 1 bit, one-cycle result-valid pulse that drives the downstream normalizer's done input.

Function
REQ-012 The FSM SHALL use states IDLE, MUL, NORM, DONE.
REQ-013 In IDLE, start=1 SHALL capture a/b and move to MUL.
- Operand unpack: hidden bit = (exp != 0).
- Unbiased exponent = exp-127 for a normal operand, -126 for a denormal.
- Exponent sum is formed at 10-bit signed width.
REQ-014 MUL SHALL run a 24x24 shift-add multiply, one multiplier bit per cycle, exactly 24 cycles, into a 48-bit product register.
REQ-015 NORM first cycle:
- if product[47]=1: shift right by 1 and add 1 to the exponent;
- then left-shift by 1 per cycle while product[46]=0, decrementing the exponent each shift.
REQ-016 NORM SHALL exit when product[46]=1 or after 47 total shifts, whichever comes first.
REQ-017 Normal x normal operands SHALL spend exactly one cycle in NORM.
REQ-018 On NORM exit, nMantissa SHALL be loaded with product[46:23].
REQ-019 On NORM exit, uExp SHALL be loaded with the exponent clamped to [-256, 255]; values below -256 give 9'h100.
REQ-020 If either operand is zero (exp=0 and fraction=0), outputs SHALL be nMantissa=0 and uExp=9'h100 (forces downstream underflow); latency is unchanged.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-022 sign, nMantissa and uExp SHALL be stable from the cycle done rises until the next done.
REQ-023 For normal operands, done SHALL be high exactly 26 cycles after the start-accept edge (1 capture, 24 MUL, 1 NORM).
REQ-024 start while busy=1 SHALL be ignored; no queuing.
REQ-025 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-026 Inf/NaN operands are not detected; they are processed as normal numbers with exponent 128, and the downstream overflow check handles them.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE and clear outputs: busy=0, done=0, sign=0, nMantissa=0, uExp=0.
REQ-028 rst SHALL take priority over start.
REQ-029 Reset mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-030 Macro FP_MUL_ROUND_EN, when defined, SHALL enable round-to-nearest-even on NORM exit:
- guard = product[22], sticky = OR(product[21:0]);
- increment when guard & (sticky | product[23]);
- mantissa carry-out re-normalizes to 24'h800000 with uExp+1, clamped at 255.
- This adds one NORM cycle, so normal-operand latency becomes 27.
REQ-031 When FP_MUL_ROUND_EN is undefined, the mantissa SHALL be truncated and latency is 26.

Verification
REQ-032 a=32'h3F800000, b=32'h3F800000 -> nMantissa=24'h800000, uExp=9'h000, sign=0, done at cycle 26.
REQ-033 a=32'hC0400000, b=32'h40800000 -> nMantissa=24'hC00000, uExp=9'h003, sign=1.
REQ-034 a=32'h7F7FFFFF, b=32'h7F7FFFFF -> nMantissa=24'hFFFFFE, uExp=9'h0FF, in both macro settings.
REQ-035 a=32'h00000000, b=32'h3FC00000 -> nMantissa=0, uExp=9'h100, one done pulse.
REQ-036 a=32'h00400000, b=32'h3F800000 (denormal) -> nMantissa=24'h800000, uExp=9'h181 (-127), with multiple NORM cycles.
REQ-037 start pulsed at cycle 5 of an operation, and rst at cycle 10 of a second operation -> first: single done and unchanged result; second: busy=0 next cycle and no done.
